// File: rtl/note_highway_scorer.sv
// note_highway_scorer: captures beat-clocked notes, scrolls them down a highway, and judges strums for score and combo.
// Optional STREAK_MULT_EN scales hit points by a combo-based multiplier (1..4).
module note_highway_scorer #(
  parameter int DEPTH    = 16,
  parameter int HIT_ROWS = 2,
  parameter int POINTS   = 10,
  parameter int SCORE_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 beat_clk,
  input  logic [4:0]           note_in,
  input  logic                 scroll_tick,
  input  logic [4:0]           fret,
  input  logic                 strum,
  output logic [5*DEPTH-1:0]   lane_rows,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           combo,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [1:0]         beat_sync_q;
  logic               beat_prev_q, beat_edge;
  logic [4:0]         note_s1_q, note_s2_q, pend_row_q;
  logic               pend_v_q;
  logic [4:0]         rows_q [DEPTH];
  logic [4:0]         rows_d [DEPTH];
  logic [4:0]         post [DEPTH];
  logic [SCORE_W-1:0] score_q, score_d, pts;
  logic [SCORE_W:0]   sum;
  logic [7:0]         combo_q, combo_d;
  logic               hit_q, miss_q, hit, over, drop, tgt_v;
  logic [IW-1:0]      tgt_idx;
  assign beat_edge = beat_sync_q[1] & ~beat_prev_q;
`ifdef STREAK_MULT_EN
  localparam int PW = SCORE_W + 3;
  logic [2:0]    mult;
  logic [PW-1:0] prod;
  always_comb begin
    mult = (combo_q >= 8'd30) ? 3'd4 : 3'(combo_q / 8'd10) + 3'd1;
    prod = PW'(POINTS) * PW'(mult);
    pts  = (prod > PW'({SCORE_W{1'b1}})) ? '1 : prod[SCORE_W-1:0];
  end
`else
  assign pts = SCORE_W'(POINTS);
`endif
  always_comb begin
    tgt_v   = 1'b0;
    tgt_idx = '0;
    for (int r = DEPTH - HIT_ROWS; r < DEPTH; r++)
      if (rows_q[r] != 5'd0) begin
        tgt_v   = 1'b1;
        tgt_idx = IW'(r);
      end
    hit  = strum && tgt_v && (fret == rows_q[tgt_idx]);
    over = strum && !hit;
    for (int r = 0; r < DEPTH; r++)
      post[r] = (hit && tgt_idx == IW'(r)) ? 5'd0 : rows_q[r];
    // the shift sees post-judge rows, so a note hit this cycle is never also dropped
    drop = scroll_tick && (post[DEPTH-1] != 5'd0);
    rows_d[0] = scroll_tick ? (pend_v_q ? pend_row_q : 5'd0) : post[0];
    for (int r = 1; r < DEPTH; r++)
      rows_d[r] = scroll_tick ? post[r-1] : post[r];
    sum     = {1'b0, score_q} + {1'b0, pts};
    score_d = !hit ? score_q : sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    combo_d = (over || drop) ? 8'd0 : !hit ? combo_q : (combo_q == 8'hff) ? combo_q : combo_q + 8'd1;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      beat_sync_q <= '0;
      beat_prev_q <= 1'b0;
      note_s1_q   <= '0;
      note_s2_q   <= '0;
      pend_row_q  <= '0;
      pend_v_q    <= 1'b0;
      rows_q      <= '{default: 5'd0};
      score_q     <= '0;
      combo_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      beat_sync_q <= {beat_sync_q[0], beat_clk};
      beat_prev_q <= beat_sync_q[1];
      note_s1_q   <= note_in;
      note_s2_q   <= note_s1_q;
      pend_row_q  <= beat_edge ? note_s2_q : pend_row_q;
      pend_v_q    <= beat_edge | (pend_v_q & ~scroll_tick);
      rows_q      <= rows_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      hit_q       <= hit;
      miss_q      <= over | drop;
    end
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign lane_rows[5*g +: 5] = rows_q[g];
  end
  assign score      = score_q;
  assign combo      = combo_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
endmodule

// File: tb/tb_note_highway_scorer.sv
// tb_note_highway_scorer: directed scoreboard bench for note_highway_scorer (honours STREAK_MULT_EN).
module tb_note_highway_scorer;
  localparam int DEPTH = 16, HIT_ROWS = 2, POINTS = 10, SCORE_W = 16;
  typedef struct {
    logic [5*DEPTH-1:0] rows;
    logic [15:0]        score;
    logic [7:0]         combo;
    logic               hit, miss;
  } exp_t;
  logic CLK = 0, RESET = 1, beat_clk = 0, scroll_tick = 0, strum = 0;
  logic [4:0] note_in = 0, fret = 0;
  logic [5*DEPTH-1:0] lane_rows;
  logic [SCORE_W-1:0] score, s0;
  logic [7:0] combo;
  logic hit_pulse, miss_pulse;
  exp_t sb[$];
  logic [4:0] m_rows [DEPTH];
  logic [4:0] m_pend;
  logic m_pv;
  int m_score, m_combo;
  int n_assert = 0, n_fail = 0;
  note_highway_scorer #(.DEPTH(DEPTH), .HIT_ROWS(HIT_ROWS), .POINTS(POINTS), .SCORE_W(SCORE_W)) dut (
    .CLK(CLK), .RESET(RESET), .beat_clk(beat_clk), .note_in(note_in), .scroll_tick(scroll_tick),
    .fret(fret), .strum(strum), .lane_rows(lane_rows), .score(score), .combo(combo),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) m_rows[r] = 0;
    m_pend = 0; m_pv = 0; m_score = 0; m_combo = 0;
  endtask
  function automatic int model_pts();
`ifdef STREAK_MULT_EN
    return POINTS * ((m_combo >= 30) ? 4 : m_combo / 10 + 1);
`else
    return POINTS;
`endif
  endfunction
  task automatic step(input logic s, input logic [4:0] f, input logic sc);
    exp_t e;
    int t;
    logic h, mi;
    strum = s; fret = f; scroll_tick = sc;
    t = -1;
    for (int r = DEPTH - 1; r >= DEPTH - HIT_ROWS; r--)
      if (m_rows[r] != 0) begin t = r; break; end
    h = 0;
    if (s && t >= 0) h = (m_rows[t] == f);
    mi = s && !h;
    if (h) begin
      m_rows[t] = 0;
      m_score = m_score + model_pts();
      if (m_score > 65535) m_score = 65535;
      if (m_combo < 255) m_combo++;
    end else if (mi) m_combo = 0;
    if (sc) begin
      if (m_rows[DEPTH-1] != 0) begin mi = 1; m_combo = 0; end
      for (int r = DEPTH - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
      m_rows[0] = m_pv ? m_pend : 5'd0;
      m_pv = 0;
    end
    for (int r = 0; r < DEPTH; r++) e.rows[5*r +: 5] = m_rows[r];
    e.score = 16'(m_score); e.combo = 8'(m_combo); e.hit = h; e.miss = mi;
    sb.push_back(e);
    @(posedge CLK); #1;
    strum = 0; scroll_tick = 0; fret = 0;
    e = sb.pop_front();
    chk("lane_rows", lane_rows, e.rows);
    chk("score", score, e.score);
    chk("combo", combo, e.combo);
    chk("hit_pulse", hit_pulse, e.hit);
    chk("miss_pulse", miss_pulse, e.miss);
  endtask
  task automatic beat(input logic [4:0] n);
    note_in = n; beat_clk = 1;
    repeat (4) step(0, 0, 0);
    beat_clk = 0; m_pend = n; m_pv = 1;
    repeat (3) step(0, 0, 0);
  endtask
  task automatic spawn(input logic [4:0] n);
    beat(n);
    step(0, 0, 1);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rows", lane_rows, 0);
    chk("rst_score", score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
    RESET = 0;
    step(0, 0, 0);
    spawn(5'b10000);
    chk("spawn_row0", lane_rows[4:0], 5'b10000);
    chk("spawn_rest", lane_rows >> 5, 0);
    repeat (15) step(0, 0, 1);
    step(1, 5'b10000, 0);
    chk("first_hit_score", score, 10);
    chk("first_hit_combo", combo, 1);
    chk("first_hit_row", lane_rows[79:75], 0);
    spawn(5'b00100);
    repeat (15) step(0, 0, 1);
    step(1, 5'b00010, 0);
    chk("wrong_fret_row", lane_rows[79:75], 5'b00100);
    chk("wrong_fret_miss", miss_pulse, 1);
    chk("wrong_fret_score", score, 10);
    step(0, 0, 1);
    beat(5'b01000);
    beat(5'b00011);
    step(0, 0, 1);
    chk("overwrite_row0", lane_rows[4:0], 5'b00011);
    spawn(5'b00001); spawn(5'b00010); spawn(5'b00100);
    for (int i = 0; i < 60; i++) begin
      if (m_rows[DEPTH-1] != 0) step(1, m_rows[DEPTH-1], 0);
      else step(0, 0, 1);
    end
    chk("combo_before_drop", combo, 4);
    spawn(5'b00001);
    repeat (16) step(0, 0, 1);
    chk("drop_miss", miss_pulse, 1);
    chk("drop_combo", combo, 0);
    spawn(5'b01010);
    repeat (15) step(0, 0, 1);
    s0 = score;
    step(1, 5'b01010, 1);
    chk("simul_hit", hit_pulse, 1);
    chk("simul_nomiss", miss_pulse, 0);
    chk("simul_score", score - s0, 10);
    step(1, 5'b00001, 0);
    chk("empty_overstrum", miss_pulse, 1);
    for (int i = 1; i <= 12; i++) spawn(5'(i));
    repeat (4) step(0, 0, 1);
    s0 = score;
    for (int i = 0; i < 12; i++) begin
      step(1, m_rows[DEPTH-1], 0);
      step(0, 0, 1);
    end
`ifdef STREAK_MULT_EN
    chk("streak_score", score - s0, 140);
`else
    chk("streak_score", score - s0, 120);
`endif
    chk("streak_combo", combo, 12);
    spawn(5'b11111);
    RESET = 1;
    #1;
    chk("async_rst_rows", lane_rows, 0);
    chk("async_rst_score", score, 0);
    chk("async_rst_combo", combo, 0);
    #2;
    RESET = 0;
    model_reset();
    step(0, 0, 1);
    step(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
